// File: rtl/cla_pkg.sv
// Shared definitions for the chunked carry-lookahead adders.
// Contents: chunk width, controller FSM state type, and helpers that derive the
// chunk count and the chunk-index counter width from an operand width.
package cla_pkg;

    localparam int unsigned CHUNK_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of CHUNK_W-bit chunks in a WIDTH-bit operand
    function automatic int unsigned calc_nchunk(input int unsigned width);
        return width / CHUNK_W;
    endfunction

    // Chunk-index counter width, never narrower than one bit
    function automatic int unsigned calc_cw(input int unsigned width);
        int unsigned n;
        n = width / CHUNK_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla6_slice.sv
// Combinational 6-bit generate/propagate carry-lookahead adder slice.
// Ports:
//   a6, b6 : 6-bit addends
//   cin    : carry into bit 0
//   s6     : 6-bit sum
//   c5     : carry into bit 5 (used for signed-overflow detection)
//   cout   : carry out of bit 5
module cla6_slice (
    input  logic [5:0] a6,
    input  logic [5:0] b6,
    input  logic       cin,
    output logic [5:0] s6,
    output logic       c5,
    output logic       cout
);

    logic [5:0] w_g;
    logic [5:0] w_p;
    logic [6:1] w_c;

    assign w_g = a6 & b6;
    assign w_p = a6 ^ b6;

    // Flattened lookahead equations: every carry depends only on g, p and cin
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0])
                  | (&w_p[2:0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1])
                  | (&w_p[3:1] & w_g[0]) | (&w_p[3:0] & cin);
    assign w_c[5] = w_g[4] | (w_p[4] & w_g[3]) | (&w_p[4:3] & w_g[2])
                  | (&w_p[4:2] & w_g[1]) | (&w_p[4:1] & w_g[0])
                  | (&w_p[4:0] & cin);
    assign w_c[6] = w_g[5] | (w_p[5] & w_g[4]) | (&w_p[5:4] & w_g[3])
                  | (&w_p[5:3] & w_g[2]) | (&w_p[5:2] & w_g[1])
                  | (&w_p[5:1] & w_g[0]) | (&w_p[5:0] & cin);

    assign s6   = w_p ^ {w_c[5:1], cin};
    assign c5   = w_c[5];
    assign cout = w_c[6];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Serial add/subtract sequencer: one shared 6-bit CLA slice processes a
// WIDTH-bit operation one chunk per cycle, LSB chunk first, with the chunk
// carry registered between cycles. One operation in flight at a time.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   op                  : 0 = a+b, 1 = a-b
//   a, b                : WIDTH-bit operands
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
module cla_serial_add_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH);
    localparam int unsigned CW     = calc_cw(WIDTH);

    if (((WIDTH % CHUNK_W) != 0) || (WIDTH < CHUNK_W)) begin : g_bad_width
        $error("cla_serial_add_ctrl: WIDTH must be a non-zero multiple of 6");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_idx;
    logic             r_carry;

    logic [31:0]      w_base;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_mask;
    logic [5:0]       w_s6;
    logic             w_c5;
    logic             w_cout;
    logic             w_last;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_last    = (r_idx == CW'(NCHUNK - 1));

    // Steer the current chunk onto the shared slice via shifts
    assign w_base = CHUNK_W * 32'(r_idx);
    assign w_a_sh = r_a >> w_base;
    assign w_b_sh = r_b >> w_base;
    assign w_mask = WIDTH'(6'h3f) << w_base;

    cla6_slice u_slice (
        .a6   (w_a_sh[5:0]),
        .b6   (w_b_sh[5:0]),
        .cin  (r_carry),
        .s6   (w_s6),
        .c5   (w_c5),
        .cout (w_cout)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-chunk datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert b, seed carry with op
                        r_a     <= a;
                        r_b     <= op ? ~b : b;
                        r_carry <= op;
                        r_idx   <= '0;
                        sum     <= '0;
                    end
                end
                ST_RUN: begin
                    sum     <= (sum & ~w_mask) | (WIDTH'(w_s6) << w_base);
                    r_carry <= w_cout;
                    r_idx   <= r_idx + CW'(1);
                    if (w_last) begin
                        cout <= w_cout;
                        ovf  <= w_c5 ^ w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed self-checking bench for cla_serial_add_ctrl (WIDTH=24).
// Expected results come from a full-width arithmetic model pushed into a
// scoreboard queue at acceptance and popped when the result appears.
module tb_cla_serial_add_ctrl;

    localparam int unsigned W      = 24;
    localparam int unsigned NCHUNK = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    cla_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sub);
        exp_t         r;
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic [W-1:0] low;
        yy     = sub ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + (W+1)'(sub);
        low    = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(sub);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation in IDLE; returns the cycle of the accepting edge
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        output int acc);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        a = x; b = y; op = sub; in_valid = 1'b1;
        sb.push_back(model(x, y, sub));
        tick();
        acc = cyc;
        in_valid = 1'b0;
        chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Bounded wait for out_valid, checking latency from acceptance
    task automatic wait_valid(input string tag, input int acc);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - acc), 32'(NCHUNK));
    endtask

    task automatic check_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb[0];
            chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sub);
        int acc;
        send(x, y, sub, acc);
        wait_valid(tag, acc);
        check_front(tag);
        drain();
    endtask

    initial begin
        int   acc;
        int   acc2;
        int   results;
        logic pre;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Arithmetic corners
        do_op("add_ripple", 24'h00FFFF, 24'h000001, 1'b0);
        chk("add_ripple_const", 32'(model(24'h00FFFF, 24'h000001, 1'b0).sum), 32'h010000);
        do_op("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0);
        do_op("add_ovf", 24'h7FFFFF, 24'h000001, 1'b0);
        do_op("sub_borrow", 24'h000005, 24'h000007, 1'b1);
        do_op("sub_ovf", 24'h800000, 24'h000001, 1'b1);
        do_op("add_mix", 24'hA5C3F0, 24'h5A3C0F, 1'b0);
        do_op("sub_mix", 24'h123456, 24'h654321, 1'b1);

        // Backpressure: hold DONE while in_valid and operands toggle
        send(24'h123456, 24'h111111, 1'b0, acc);
        wait_valid("bp", acc);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            a = W'($urandom);
            b = W'($urandom);
            op = 1'($urandom);
            tick();
            check_front("bp_hold");
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        e = sb[0];
        drain();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_sum_held", 32'(sum), 32'(e.sum));

        // Reset in the middle of RUN (during chunk 2)
        send(24'h0ABCDE, 24'h012345, 1'b0, acc);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        do_op("after_rst", 24'h000003, 24'h000004, 1'b0);
        chk("after_rst_const", 32'(sum), 32'h000007);

        // Back-to-back with in_valid held and out_ready high
        out_ready = 1'b1;
        a = 24'h0F0F0F; b = 24'h010101; op = 1'b0; in_valid = 1'b1;
        sb.push_back(model(a, b, op));
        pre = in_ready;
        tick();
        chk("b2b_first_accept", 32'(pre), 32'd1);
        acc = cyc;
        acc2 = -1;
        a = 24'h400000; b = 24'h400001; op = 1'b1;
        sb.push_back(model(a, b, op));
        results = 0;
        for (int k = 0; k < 40 && results < 2; k++) begin
            pre = in_ready;
            tick();
            if (pre && acc2 < 0) begin
                acc2 = cyc;
                in_valid = 1'b0;
            end
            if (out_valid) begin
                check_front("b2b_result");
                if (sb.size() != 0) void'(sb.pop_front());
                results++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", 32'(results), 32'd2);
        chk("b2b_spacing", 32'(acc2 - acc), 32'(NCHUNK + 2));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
- Sequencer that time-shares one 6-bit carry-lookahead slice to add or subtract two WIDTH-bit operands, one 6-bit chunk per cycle, LSB chunk first.
- Chunk carry-out is registered and fed back as the next chunk's carry-in.
- Sits between the pixel-key comparator front end and the sort network. Wide key arithmetic costs WIDTH/6 cycles instead of a full-width CLA tree.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 24, operand/result width in bits; must be a multiple of 6 and at least 6 (elaboration error otherwise).
- NCHUNK, WIDTH/6, derived chunk count; not to be overridden.
- CW, clog2(NCHUNK) (minimum 1), derived chunk-index counter width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- op  input  1  0 = a+b, 1 = a-b (a + ~b + 1).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB xor carry out of MSB.

Behaviour:
- Reset (sampled at clk edge while rst=1):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry register=0.
  - rst overrides everything, including mid-RUN or DONE; any in-flight operation is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), purely combinational from state.
  - out_valid = (state==DONE), registered state.
- IDLE:
  - On in_valid & in_ready, latch a, (op ? ~b : b) into operand registers.
  - Set carry=op, idx=0, clear sum, go to RUN.
- RUN, each cycle processes chunk idx on bits [6*idx+5 : 6*idx]:
  - g = a_chunk & b_chunk; p = a_chunk ^ b_chunk.
  - Internal carries from the lookahead slice with cin = carry register.
  - sum chunk = p ^ {c5..c1, cin}.
  - Chunk carry-out = g5 | (p5 & c5) is written to the carry register.
  - idx increments. When idx==NCHUNK-1: write cout = chunk carry-out, ovf = c5 ^ chunk carry-out, go to DONE.
- Latency:
  - Acceptance at edge T gives out_valid high after edge T+NCHUNK.
  - WIDTH=6 gives exactly 1 RUN cycle.
- DONE:
  - sum/cout/ovf are held stable while out_ready=0 (no limit on stall length).
  - On out_ready=1, go to IDLE. in_ready rises the next cycle, so there is no same-cycle accept-on-drain.
  - Maximum throughput is one operation per NCHUNK+2 cycles.
- Outputs outside DONE:
  - sum/cout/ovf keep their last values; they are only meaningful while out_valid=1.
  - sum may be partially updated during RUN.
- Handshake rules:
  - in_valid outside IDLE is ignored; no stall of a, b, or op is required after acceptance.
  - out_ready outside DONE is ignored.
- Arithmetic: modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package cla_pkg holds:
  - CHUNK_W = 6.
  - FSM state enum {IDLE, RUN, DONE} (2-bit encoding).
  - Function computing NCHUNK/CW from WIDTH.
- Sub-module cla6_slice: combinational 6-bit g/p/carry-lookahead slice.
  - Inputs: a6, b6, cin.
  - Outputs: s6, c5, cout.
  - Reusable by other wide adders.
- The controller instantiates exactly one cla6_slice, muxed onto the current chunk.

Test Plan (WIDTH=24, NCHUNK=4):
- Add 0x00FFFF + 0x000001, op=0 -> out_valid 4 cycles after accept; sum=0x010000, cout=0, ovf=0; carry ripples across the chunk 1/2 boundary.
- Add 0xFFFFFF + 0x000001 -> sum=0x000000, cout=1, ovf=0. Then 0x7FFFFF + 0x000001 -> sum=0x800000, cout=0, ovf=1.
- Subtract, op=1: 5 - 7 -> sum=0xFFFFFE, cout=0 (borrow), ovf=0. Then 0x800000 - 0x000001 -> sum=0x7FFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> sum/cout/ovf stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst during chunk 2 -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0. A following 0x000003 + 0x000004 yields 0x000007 with normal latency.
- Back-to-back: two ops with in_valid held high and out_ready=1 -> second accepted exactly NCHUNK+2 cycles after the first; both results correct and in order.
